// File: rtl/seg7_display_ctrl.sv
// Hex 7-segment controller: static per-digit outputs plus a multiplexed scan port,
// with leading-zero suppression and per-digit blinking. All outputs are registered.
module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25000000,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      blank_lz,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      scan_en,
  output logic [7*NUM_DIGITS-1:0]   seg_all,
  output logic [6:0]                scan_seg,
  output logic [NUM_DIGITS-1:0]     scan_sel
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCW   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam int SCW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
      $error("seg7_display_ctrl: NUM_DIGITS must be 1..8");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink_div
      $error("seg7_display_ctrl: BLINK_DIV must be >= 2");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan_div
      $error("seg7_display_ctrl: SCAN_DIV must be >= 1");
    end
  endgenerate

  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [4*NUM_DIGITS-1:0]   r_value;
  logic [BCW-1:0]            r_bcnt;
  logic                      r_phase;
  logic [SCW-1:0]            r_scnt;
  logic [IDX_W-1:0]          r_idx;

  logic [SCW-1:0]            w_scnt_nxt;
  logic [IDX_W-1:0]          w_idx_nxt;
  logic [6:0]                w_scan_seg_nxt;
  logic [NUM_DIGITS-1:0]     w_scan_sel_nxt;
  logic [NUM_DIGITS-1:0]     w_lz;
  logic                      w_run;
  logic [7*NUM_DIGITS-1:0]   w_seg;

  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Walk down from the top digit; the run of zeros ends at the first nonzero nibble.
  always_comb begin
    w_lz  = '0;
    w_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (w_run && r_value[4*i +: 4] == 4'h0) begin
        w_lz[i] = 1'b1;
      end else begin
        w_run = 1'b0;
      end
    end
  end

  always_comb begin
    w_seg = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((blank_lz && w_lz[i]) || (blink_mask[i] && r_phase)) begin
        w_seg[7*i +: 7] = 7'h7F;
      end else begin
        w_seg[7*i +: 7] = enc(r_value[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Leaving SCAN zeroes the slot counter and index so re-entry always starts at digit 0.
  always_comb begin
    w_state_nxt    = r_state;
    w_scnt_nxt     = '0;
    w_idx_nxt      = '0;
    w_scan_seg_nxt = 7'h7F;
    w_scan_sel_nxt = '1;
    case (r_state)
      S_IDLE: begin
        if (scan_en) w_state_nxt = S_SCAN;
      end
      S_SCAN: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (r_idx == IDX_W'(i)) begin
            w_scan_seg_nxt    = w_seg[7*i +: 7];
            w_scan_sel_nxt[i] = 1'b0;
          end
        end
        if (!scan_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_scnt == SCW'(SCAN_DIV - 1)) begin
          w_scnt_nxt = '0;
          w_idx_nxt  = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
          w_scnt_nxt = r_scnt + SCW'(1);
          w_idx_nxt  = r_idx;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value  <= '0;
      r_bcnt   <= '0;
      r_phase  <= 1'b0;
      r_scnt   <= '0;
      r_idx    <= '0;
      seg_all  <= '1;
      scan_seg <= 7'h7F;
      scan_sel <= '1;
    end else begin
      if (load) r_value <= value;
      if (r_bcnt == BCW'(BLINK_DIV - 1)) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + BCW'(1);
      end
      r_scnt   <= w_scnt_nxt;
      r_idx    <= w_idx_nxt;
      seg_all  <= w_seg;
      scan_seg <= w_scan_seg_nxt;
      scan_sel <= w_scan_sel_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Bench for seg7_display_ctrl (4 digits, blink half-period 4, scan slot 2):
// directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_seg7_display_ctrl;
  localparam int ND = 4;
  localparam int BD = 4;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic        scan_en = 1'b0;
  logic [27:0] seg_all;
  logic [6:0]  scan_seg;
  logic [3:0]  scan_sel;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] enc_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: value register, edges since reset, scan activity and edges spent scanning.
  logic [15:0] m_val;
  int          m_edges;
  bit          m_scan;
  int          m_k;
  logic [27:0] e_seg;
  logic [6:0]  e_sseg;
  logic [3:0]  e_ssel;

  seg7_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_lz(blank_lz),
    .blink_mask(blink_mask), .scan_en(scan_en), .seg_all(seg_all),
    .scan_seg(scan_seg), .scan_sel(scan_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // A digit is blank if it blinks in the off phase, or if it and everything above it is zero.
  function automatic logic [27:0] model_seg(input logic [15:0] v, input logic blz,
                                            input logic [3:0] msk, input bit ph);
    logic [27:0] r;
    logic [3:0]  nib;
    bit          blank;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      nib   = v[4*i +: 4];
      blank = (ph && msk[i]) || (blz && i > 0 && (v >> (4*i)) == 16'h0);
      r[7*i +: 7] = blank ? 7'h7F : enc_tab[nib];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_val   = '0;
    m_edges = 0;
    m_scan  = 0;
    m_k     = 0;
    e_seg   = '1;
    e_sseg  = 7'h7F;
    e_ssel  = 4'hF;
  endtask

  // Advance one clock: predict the registered outputs, update the model, land on the next negedge.
  task automatic tick();
    int idx;
    if (rst) begin
      e_seg = model_seg(m_val, blank_lz, blink_mask, ((m_edges / BD) % 2) == 1);
      if (m_scan) begin
        idx    = (m_k / SD) % ND;
        e_sseg = e_seg[7*idx +: 7];
        e_ssel = ~(4'b0001 << idx);
      end else begin
        e_sseg = 7'h7F;
        e_ssel = 4'hF;
      end
      if (load) m_val = value;
      m_edges++;
      if (m_scan && scan_en) m_k++;
      else m_k = 0;
      m_scan = scan_en;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    load  = 1'b1;
    value = 16'hABCD;
    model_reset();
    #1;
    n_cmp++; if (seg_all !== 28'hFFFFFFF) begin n_bad++; $display("FAIL reset_seg_all: got %h want %h", seg_all, 28'hFFFFFFF); end
    n_cmp++; if (scan_seg !== 7'h7F) begin n_bad++; $display("FAIL reset_scan_seg: got %h want 7f", scan_seg); end
    n_cmp++; if (scan_sel !== 4'hF) begin n_bad++; $display("FAIL reset_scan_sel: got %b want 1111", scan_sel); end
    @(negedge clk);
    tick();
    tick();
    n_cmp++; if (seg_all !== 28'hFFFFFFF) begin n_bad++; $display("FAIL reset_hold_load_ignored: got %h want %h", seg_all, 28'hFFFFFFF); end
    load = 1'b0;
    rst  = 1'b1;
    tick();
    n_cmp++; if (seg_all !== {4{7'h40}}) begin n_bad++; $display("FAIL first_edge_zero: got %h want %h", seg_all, {4{7'h40}}); end
    n_cmp++; if (seg_all !== e_seg) begin n_bad++; $display("FAIL first_edge_model: got %h want %h", seg_all, e_seg); end
  endtask

  task automatic test_load_lz();
    value = 16'h12AF; load = 1'b1; blank_lz = 1'b0; blink_mask = '0;
    tick();
    load = 1'b0;
    n_cmp++; if (seg_all !== {4{7'h40}}) begin n_bad++; $display("FAIL load_latency: got %h want %h", seg_all, {4{7'h40}}); end
    tick();
    n_cmp++; if (seg_all !== {7'h79, 7'h24, 7'h08, 7'h0E}) begin n_bad++; $display("FAIL load_12af: got %h want %h", seg_all, {7'h79, 7'h24, 7'h08, 7'h0E}); end
    n_cmp++; if (seg_all !== e_seg) begin n_bad++; $display("FAIL load_12af_model: got %h want %h", seg_all, e_seg); end
    value = 16'h0050; load = 1'b1; blank_lz = 1'b1;
    tick();
    load = 1'b0;
    tick();
    n_cmp++; if (seg_all !== {7'h7F, 7'h7F, 7'h12, 7'h40}) begin n_bad++; $display("FAIL lz_0050: got %h want %h", seg_all, {7'h7F, 7'h7F, 7'h12, 7'h40}); end
    value = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    n_cmp++; if (seg_all !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin n_bad++; $display("FAIL lz_0000: got %h want %h", seg_all, {7'h7F, 7'h7F, 7'h7F, 7'h40}); end
    blank_lz = 1'b0;
    tick();
    n_cmp++; if (seg_all !== {4{7'h40}}) begin n_bad++; $display("FAIL lz_off_one_edge: got %h want %h", seg_all, {4{7'h40}}); end
  endtask

  task automatic test_blink();
    int saw_on;
    int saw_off;
    saw_on = 0; saw_off = 0;
    value = 16'h1234; load = 1'b1; blank_lz = 1'b0;
    tick();
    load = 1'b0; blink_mask = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++; if (seg_all !== e_seg) begin n_bad++; $display("FAIL blink_model c%0d: got %h want %h", c, seg_all, e_seg); end
      if (c > 0) begin
        n_cmp++; if (seg_all[27:7] !== {7'h79, 7'h24, 7'h30}) begin n_bad++; $display("FAIL blink_steady c%0d: got %h want %h", c, seg_all[27:7], {7'h79, 7'h24, 7'h30}); end
        if (seg_all[6:0] === 7'h19) saw_on++;
        if (seg_all[6:0] === 7'h7F) saw_off++;
      end
    end
    n_cmp++; if (saw_on + saw_off != 19 || saw_on < 7 || saw_off < 7) begin n_bad++; $display("FAIL blink_alternate: got on=%0d off=%0d want both >=7 summing to 19", saw_on, saw_off); end
  endtask

  task automatic test_scan();
    logic [3:0] sel_tab [4];
    logic [6:0] seg_tab [4];
    sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{7'h19, 7'h30, 7'h24, 7'h79};
    blink_mask = '0; blank_lz = 1'b0; scan_en = 1'b1;
    tick();
    n_cmp++; if (scan_sel !== 4'hF) begin n_bad++; $display("FAIL scan_entry_idle: got %b want 1111", scan_sel); end
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < SD; c++) begin
        tick();
        n_cmp++; if (scan_sel !== sel_tab[s % 4]) begin n_bad++; $display("FAIL scan_sel s%0d: got %b want %b", s, scan_sel, sel_tab[s % 4]); end
        n_cmp++; if (scan_seg !== seg_tab[s % 4]) begin n_bad++; $display("FAIL scan_seg s%0d: got %h want %h", s, scan_seg, seg_tab[s % 4]); end
        n_cmp++; if (scan_sel !== e_ssel || scan_seg !== e_sseg) begin n_bad++; $display("FAIL scan_model s%0d: got %b/%h want %b/%h", s, scan_sel, scan_seg, e_ssel, e_sseg); end
      end
    end
  endtask

  task automatic test_rst_mid_scan();
    for (int c = 0; c < 20 && scan_sel !== 4'b1011; c++) tick();
    n_cmp++; if (scan_sel !== 4'b1011 || e_ssel !== 4'b1011) begin n_bad++; $display("FAIL mid_scan_reach_idx2: got %b model %b want 1011", scan_sel, e_ssel); end
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (scan_sel !== 4'hF) begin n_bad++; $display("FAIL mid_rst_sel: got %b want 1111", scan_sel); end
    n_cmp++; if (scan_seg !== 7'h7F) begin n_bad++; $display("FAIL mid_rst_seg: got %h want 7f", scan_seg); end
    n_cmp++; if (seg_all !== 28'hFFFFFFF) begin n_bad++; $display("FAIL mid_rst_seg_all: got %h want %h", seg_all, 28'hFFFFFFF); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (scan_sel !== 4'b1110 || scan_seg !== 7'h40) begin n_bad++; $display("FAIL rescan_idx0: got %b/%h want 1110/40", scan_sel, scan_seg); end
    n_cmp++; if (scan_sel !== e_ssel || scan_seg !== e_sseg || seg_all !== e_seg) begin n_bad++; $display("FAIL rescan_model: got %b/%h/%h want %b/%h/%h", scan_sel, scan_seg, seg_all, e_ssel, e_sseg, e_seg); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      load  = ($urandom_range(0, 3) == 0);
      value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      blank_lz = 1'($urandom);
      if (c % 8 == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) scan_en = ~scan_en;
      tick();
      n_cmp++; if (seg_all !== e_seg) begin n_bad++; $display("FAIL rand_seg_all c%0d: got %h want %h", c, seg_all, e_seg); end
      n_cmp++; if (scan_seg !== e_sseg) begin n_bad++; $display("FAIL rand_scan_seg c%0d: got %h want %h", c, scan_seg, e_sseg); end
      n_cmp++; if (scan_sel !== e_ssel) begin n_bad++; $display("FAIL rand_scan_sel c%0d: got %b want %b", c, scan_sel, e_ssel); end
    end
  endtask

  initial begin
    test_reset();
    test_load_lz();
    test_blink();
    test_scan();
    test_rst_mid_scan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_display_ctrl.md
SEG7_DISPLAY_CTRL -- requirements
Module: seg7_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of hex digits driven (legal 1..8).
REQ-002 Parameter BLINK_DIV, default 25000000, clk cycles per blink half-period (legal >= 2).
REQ-003 Parameter SCAN_DIV, default 50000, clk cycles per scanned digit slot (legal >= 1).
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; rst=0 resets immediately regardless of clk.
REQ-006 load  input  1  capture strobe for value.
REQ-007 value  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is digit i, digit 0 least significant.
REQ-008 blank_lz  input  1  leading-zero suppression enable.
REQ-009 blink_mask  input  NUM_DIGITS  bit i set: digit i blinks.
REQ-010 scan_en  input  1  enables multiplexed scan outputs.
REQ-011 seg_all  output  7*NUM_DIGITS  static per-digit segments; bits 7i+6:7i are digit i, ordered g..a, active-low.
REQ-012 scan_seg  output  7  segments of the currently scanned digit, active-low.
REQ-013 scan_sel  output  NUM_DIGITS  active-low one-hot digit select for scan mode.

Function
REQ-014 Encoding (hex, g..a): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E; blank=7F.
REQ-015 value_q SHALL load value on a rising edge with load=1; otherwise hold.
REQ-016 seg_all, scan_seg, scan_sel SHALL be registered; load sampled at edge k -> seg_all reflects new value after edge k+1 (latency 2 edges from strobe).
REQ-017 blank_lz and blink_mask SHALL be sampled each cycle, no load needed; effect visible after one edge.
REQ-018 With blank_lz=1, digits from NUM_DIGITS-1 downward SHALL be blank while value_q nibble is 0, stopping at first nonzero nibble; digit 0 SHALL never be lz-blanked.
REQ-019 Blink counter SHALL count 0..BLINK_DIV-1 and wrap to 0; blink_phase SHALL toggle on each wrap.
REQ-020 When blink_phase=1, every digit with blink_mask bit set SHALL show blank; blink_phase=0 shows normal pattern.
REQ-021 Blink and lz blanking SHALL combine by OR (either condition blanks).
REQ-022 Scan FSM states: IDLE, SCAN. IDLE->SCAN when scan_en=1; SCAN->IDLE when scan_en=0 (effective next edge).
REQ-023 In IDLE: scan counter and digit index held at 0; scan_sel all ones; scan_seg=7F.
REQ-024 In SCAN: scan counter counts 0..SCAN_DIV-1; on wrap, index increments, NUM_DIGITS-1 wraps to 0; entering SCAN starts at index 0.
REQ-025 In SCAN: scan_sel bit index = 0, all others 1; scan_seg equals the seg_all slice of digit index (same blanking applied).
REQ-026 SCAN_DIV=1 SHALL advance index every cycle; NUM_DIGITS=1 SHALL keep index at 0.
REQ-027 load and blink/scan counting SHALL proceed concurrently; a load mid-slot SHALL not reset scan or blink counters.
REQ-028 Illegal parameter values SHALL raise an elaboration-time error.

Reset
REQ-029 While rst=0: value_q=0, blink counter=0, blink_phase=0, scan counter=0, index=0, FSM=IDLE.
REQ-030 While rst=0: seg_all all digits 7F, scan_seg=7F, scan_sel all ones; load ignored.
REQ-031 After rst release, first rising edge SHALL compute outputs from value_q=0 (digit 0 shows 40).
REQ-032 Reset asserted mid-scan or mid-blink SHALL clear state immediately; no partial slot resumes.

Verification (NUM_DIGITS=4, BLINK_DIV=4, SCAN_DIV=2)
REQ-033 Reset release, load 0x12AF, blank_lz=0 -> seg_all after 2 edges = digits3..0: 79,24,08,0E.
REQ-034 load 0x0050, blank_lz=1 -> digits3..0: 7F,7F,12,40; load 0x0000 -> 7F,7F,7F,40.
REQ-035 value 0x1234, blink_mask=0b0001 -> digit 0 alternates 19 / 7F every 4 cycles; other digits steady.
REQ-036 scan_en=1, value 0x1234 -> scan_sel sequence 1110,1101,1011,0111 each 2 cycles, scan_seg 19,30,24,79, wrap to 1110.
REQ-037 rst pulsed low mid-scan at index 2 -> immediately scan_sel=1111, scan_seg=7F, seg_all all 7F; after release with scan_en=1, scan restarts at index 0 with value 0.
